// File: rtl/serial_magnitude_comparator_if.sv
// serial_magnitude_comparator_if
// Request/result signals of the serial magnitude comparator. The master
// (requester) drives operands and start; the slave (comparator) returns
// busy/done and the less/equal flag pair.
`timescale 1ns/1ps

interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] src_a_i;
  logic [WIDTH-1:0] src_b_i;
  logic             busy_o;
  logic             done_o;
  logic             less_o;
  logic             equal_o;

  modport master (
    output start_i, signed_i, src_a_i, src_b_i,
    input  busy_o, done_o, less_o, equal_o
  );

  modport slave (
    input  start_i, signed_i, src_a_i, src_b_i,
    output busy_o, done_o, less_o, equal_o
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Multi-cycle A/B magnitude comparator feeding the ALU's compare-select
// logic. Operands are latched on start and scanned MSB-first,
// BITS_PER_CYCLE bits per clock; the first differing group decides the
// result. Signed compares flip the sign bit at latch time so the scan is
// always unsigned.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN -- when defined, the scan
// ends at the first differing group instead of always running all groups.
`timescale 1ns/1ps

module serial_magnitude_comparator #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                        clk_i,
  input logic                        rst_n,
  serial_magnitude_comparator_if.slave bus
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  // Reject illegal group sizes at elaboration time.
  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8) ||
      (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
    $error("serial_magnitude_comparator: BITS_PER_CYCLE must be 1/2/4/8 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    decided_q, decided_d;
  logic                    dec_less_q, dec_less_d;
  logic                    less_q, less_d;
  logic                    equal_q, equal_d;

  logic [BITS_PER_CYCLE-1:0] grp_a;
  logic [BITS_PER_CYCLE-1:0] grp_b;
  logic                      grp_diff;
  logic                      grp_less;
  logic                      last_grp;
  logic                      res_decided;
  logic                      res_less;
  logic                      scan_end;

  // Current group is always the top slice, since operands shift left each scan edge.
  assign grp_a    = a_q[WIDTH-1 -: BITS_PER_CYCLE];
  assign grp_b    = b_q[WIDTH-1 -: BITS_PER_CYCLE];
  assign grp_diff = (grp_a != grp_b);
  assign grp_less = (grp_a < grp_b);
  assign last_grp = (idx_q == IDX_W'(N - 1));

  // Result as it stands after this edge: an earlier sticky decision wins.
  assign res_decided = decided_q | grp_diff;
  assign res_less    = decided_q ? dec_less_q : grp_less;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign scan_end = last_grp | grp_diff;
`else
  assign scan_end = last_grp;
`endif

  // Next-state, operand and flag computation.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    idx_d      = idx_q;
    decided_d  = decided_q;
    dec_less_d = dec_less_q;
    less_d     = less_q;
    equal_d    = equal_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          a_d        = bus.src_a_i ^ (bus.signed_i ? MSB_MASK : '0);
          b_d        = bus.src_b_i ^ (bus.signed_i ? MSB_MASK : '0);
          idx_d      = '0;
          decided_d  = 1'b0;
          dec_less_d = 1'b0;
          less_d     = 1'b0;
          equal_d    = 1'b0;
          state_d    = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SCAN: begin
        a_d   = a_q << BITS_PER_CYCLE;
        b_d   = b_q << BITS_PER_CYCLE;
        idx_d = idx_q + IDX_W'(1);
        if (!decided_q && grp_diff) begin
          decided_d  = 1'b1;
          dec_less_d = grp_less;
        end
        if (scan_end) begin
          less_d  = res_decided & res_less;
          equal_d = ~res_decided;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and flag registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    // NOTE: operand registers are reset too, so a reset mid-scan leaves no stale operand visible.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      decided_q  <= 1'b0;
      dec_less_q <= 1'b0;
      less_q     <= 1'b0;
      equal_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      idx_q      <= idx_d;
      decided_q  <= decided_d;
      dec_less_q <= dec_less_d;
      less_q     <= less_d;
      equal_q    <= equal_d;
    end
  end

  assign bus.busy_o  = (state_q == ST_SCAN);
  assign bus.done_o  = (state_q == ST_DONE);
  assign bus.less_o  = less_q;
  assign bus.equal_o = equal_q;

endmodule
